// File: rtl/ball_locator_if.sv
// Pixel-stream and result bundle for ball_locator.
// The slave side is the locator; the master side is the pixel source and result consumer.
interface ball_locator_if;
    logic       white_pixel;
    logic [9:0] x_cont;
    logic [8:0] y_cont;
    logic       h_sync;
    logic       v_sync;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [9:0] ball_width;
    logic       ball_valid;
    logic       frame_done;
    logic [1:0] dbg_state;

    modport slave (
        input  white_pixel, x_cont, y_cont, h_sync, v_sync,
        output ball_x, ball_y, ball_width, ball_valid, frame_done, dbg_state
    );

    modport master (
        output white_pixel, x_cont, y_cont, h_sync, v_sync,
        input  ball_x, ball_y, ball_width, ball_valid, frame_done, dbg_state
    );
endinterface

// File: rtl/ball_locator.sv
// Finds the longest horizontal white run per frame and publishes its latency-corrected centre.
// Optional macro BALL_LOC_HOLD_EN: keep the previous position/width on frames without a valid ball.
module ball_locator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_OFFSET = 1,
    parameter int Y_OFFSET = 2,
    parameter int MIN_RUN  = 4
) (
    input  logic          VGA_clock,
    input  logic          reset,
    ball_locator_if.slave bus
);
    typedef enum logic [1:0] {
        START_UP = 2'd0,
        WAIT     = 2'd1,
        IS_RED   = 2'd2
    } state_t;

    localparam logic [9:0]        H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0]        H_LAST_W = 10'(H_ACTIVE - 1);
    localparam logic [8:0]        V_ACT_W  = 9'(V_ACTIVE);
    localparam logic signed [10:0] X_OFF_W = 11'(X_OFFSET);
    localparam logic signed [10:0] Y_OFF_W = 11'(Y_OFFSET);
    localparam logic [9:0]        MIN_W    = 10'(MIN_RUN);

    state_t      r_state, w_next;
    logic        r_v_sync_d;
    logic [9:0]  r_cntr, r_max_ever, r_end_x;
    logic [8:0]  r_line_of_max, r_run_y;
    logic [9:0]  r_ball_x, r_ball_width;
    logic [8:0]  r_ball_y;
    logic        r_ball_valid, r_frame_done;

    logic        w_active, w_hit, w_fe;
    logic        w_start, w_inc, w_close, w_publish, w_clear;
    logic [9:0]  w_last_x;
    logic signed [10:0] w_cx, w_cy;
    logic [9:0]  w_pub_x;
    logic [8:0]  w_pub_y;
    logic        w_pub_valid;

    assign w_active = (bus.x_cont < H_ACT_W) && (bus.y_cont < V_ACT_W) && bus.h_sync;
    assign w_hit    = w_active && bus.white_pixel;
    assign w_fe     = r_v_sync_d && !bus.v_sync;
    // A run closing on column 0 or past the active area last touched the final active column.
    assign w_last_x = ((bus.x_cont == 10'd0) || (bus.x_cont >= H_ACT_W)) ? H_LAST_W
                                                                         : bus.x_cont - 10'd1;

    assign w_cx        = $signed({1'b0, r_end_x}) - $signed({2'b00, r_max_ever[9:1]}) - X_OFF_W;
    assign w_cy        = $signed({2'b00, r_line_of_max}) - Y_OFF_W;
    assign w_pub_x     = w_cx[10] ? 10'd0 : w_cx[9:0];
    assign w_pub_y     = w_cy[10] ? 9'd0 : w_cy[8:0];
    assign w_pub_valid = (r_max_ever >= MIN_W);

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_inc     = 1'b0;
        w_close   = 1'b0;
        w_publish = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            START_UP: begin
                if (w_fe) begin
                    w_next  = WAIT;
                    w_clear = 1'b1;
                end
            end
            WAIT: begin
                if (w_fe) begin
                    w_publish = 1'b1;
                    w_clear   = 1'b1;
                end else if (w_hit) begin
                    w_start = 1'b1;
                    w_next  = IS_RED;
                end
            end
            IS_RED: begin
                if (w_fe) begin
                    w_publish = 1'b1;
                    w_clear   = 1'b1;
                    w_next    = WAIT;
                end else if (w_hit) begin
                    w_inc = 1'b1;
                end else begin
                    w_close = 1'b1;
                    w_next  = WAIT;
                end
            end
            default: w_next = START_UP;
        endcase
    end

    always_ff @(posedge VGA_clock) begin
        if (reset) begin
            r_state       <= START_UP;
            r_v_sync_d    <= 1'b1;
            r_cntr        <= '0;
            r_max_ever    <= '0;
            r_end_x       <= '0;
            r_line_of_max <= '0;
            r_run_y       <= '0;
            r_ball_x      <= '0;
            r_ball_y      <= '0;
            r_ball_width  <= '0;
            r_ball_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_v_sync_d   <= bus.v_sync;
            r_frame_done <= w_publish;
            if (w_clear) begin
                r_cntr        <= '0;
                r_max_ever    <= '0;
                r_end_x       <= '0;
                r_line_of_max <= '0;
            end else begin
                if (w_start) begin
                    r_cntr  <= 10'd1;
                    r_run_y <= bus.y_cont;
                end
                if (w_inc && (r_cntr != 10'h3FF))
                    r_cntr <= r_cntr + 10'd1;
                // Strictly greater, so an equal later run never displaces the earlier one.
                if (w_close && (r_cntr > r_max_ever)) begin
                    r_max_ever    <= r_cntr;
                    r_end_x       <= w_last_x;
                    r_line_of_max <= r_run_y;
                end
            end
            if (w_publish) begin
                r_ball_valid <= w_pub_valid;
`ifdef BALL_LOC_HOLD_EN
                if (w_pub_valid) begin
                    r_ball_x     <= w_pub_x;
                    r_ball_y     <= w_pub_y;
                    r_ball_width <= r_max_ever;
                end
`else
                r_ball_x     <= w_pub_x;
                r_ball_y     <= w_pub_y;
                r_ball_width <= r_max_ever;
`endif
            end
        end
    end

    assign bus.ball_x     = r_ball_x;
    assign bus.ball_y     = r_ball_y;
    assign bus.ball_width = r_ball_width;
    assign bus.ball_valid = r_ball_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_ball_locator.sv
// Directed and random frames for ball_locator, checked against a bitmap-scanning frame model.
module tb_ball_locator;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int X_OFFSET = 1;
    localparam int Y_OFFSET = 2;
    localparam int MIN_RUN  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ball_locator_if bus();

    ball_locator #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .X_OFFSET(X_OFFSET),
        .Y_OFFSET(Y_OFFSET), .MIN_RUN(MIN_RUN)
    ) dut (
        .VGA_clock(clk),
        .reset    (rst),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference frame model: best run so far and the outputs expected to be on display.
    int m_max, m_end_x, m_line;
    bit m_started;
    int exp_x, exp_y, exp_w;
    bit exp_v;
    logic [H_ACTIVE-1:0] lb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic w, input int x, input int y, input logic hs, input logic vs);
        bus.white_pixel = w;
        bus.x_cont      = x[9:0];
        bus.y_cont      = y[8:0];
        bus.h_sync      = hs;
        bus.v_sync      = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic model_close(input int len, input int last_x, input int y);
        if (len > m_max) begin
            m_max   = len;
            m_end_x = last_x;
            m_line  = y;
        end
    endtask

    task automatic model_line(input int y, input logic [H_ACTIVE-1:0] bits);
        int len;
        len = 0;
        if (y >= V_ACTIVE) return;
        for (int x = 0; x < H_ACTIVE; x++) begin
            if (bits[x]) len++;
            else begin
                model_close(len, x - 1, y);
                len = 0;
            end
        end
        model_close(len, H_ACTIVE - 1, y);
    endtask

    task automatic add_run(input int start, input int len);
        for (int i = start; i < start + len && i < H_ACTIVE; i++) lb[i] = 1'b1;
    endtask

    task automatic drive_line(input int y, input logic [H_ACTIVE-1:0] bits);
        for (int x = 0; x < H_ACTIVE + 4; x++)
            cyc((x < H_ACTIVE) ? bits[x] : 1'($urandom_range(0, 1)), x, y, 1'b1, 1'b1);
        // Sync low over active columns with white input must not open a run.
        for (int k = 0; k < 2; k++)
            cyc(1'b1, $urandom_range(0, H_ACTIVE - 1), y, 1'b0, 1'b1);
        if (m_started) model_line(y, bits);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ball_x"},     32'(bus.ball_x),     32'(exp_x));
        check({tag, ".ball_y"},     32'(bus.ball_y),     32'(exp_y));
        check({tag, ".ball_width"}, 32'(bus.ball_width), 32'(exp_w));
        check({tag, ".ball_valid"}, 32'(bus.ball_valid), 32'(exp_v));
    endtask

    task automatic frame_end(input string tag, input bit open_run);
        int cx, cy;
        bit v;
        if (open_run)
            for (int x = 100; x < 140; x++) cyc(1'b1, x, 300, 1'b1, 1'b1);
        cyc(open_run, 140, 300, 1'b1, 1'b0);
        if (m_started) begin
            cx = m_end_x - (m_max / 2) - X_OFFSET;
            cy = m_line - Y_OFFSET;
            if (cx < 0) cx = 0;
            if (cy < 0) cy = 0;
            v = (m_max >= MIN_RUN);
            exp_v = v;
`ifdef BALL_LOC_HOLD_EN
            if (v) begin
                exp_x = cx; exp_y = cy; exp_w = m_max;
            end
`else
            exp_x = cx; exp_y = cy; exp_w = m_max;
`endif
            check({tag, ".frame_done"}, 32'(bus.frame_done), 32'd1);
        end else begin
            check({tag, ".no_frame_done"}, 32'(bus.frame_done), 32'd0);
        end
        check_outputs(tag);
        cyc(1'b0, 141, 300, 1'b1, 1'b0);
        check({tag, ".pulse_end"}, 32'(bus.frame_done), 32'd0);
        check({tag, ".hold_x"},    32'(bus.ball_x),     32'(exp_x));
        cyc(1'b0, 142, 300, 1'b1, 1'b1);
        m_started = 1'b1;
        m_max = 0; m_end_x = 0; m_line = 0;
    endtask

    initial begin
        m_max = 0; m_end_x = 0; m_line = 0; m_started = 1'b0;
        exp_x = 0; exp_y = 0; exp_w = 0; exp_v = 1'b0;
        bus.white_pixel = 1'b0; bus.x_cont = '0; bus.y_cont = '0;
        bus.h_sync = 1'b1; bus.v_sync = 1'b1;

        rst = 1'b1;
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        check_outputs("reset");
        check("reset.frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;

        frame_end("startup", 1'b0);
        frame_end("empty", 1'b0);

        lb = '0; add_run(200, 20);
        drive_line(100, lb);
        frame_end("single20", 1'b0);

        lb = '0; add_run(100, 10); drive_line(50, lb);
        lb = '0; add_run(400, 10); drive_line(60, lb);
        lb = '0; add_run(300, 12); drive_line(70, lb);
        frame_end("longest", 1'b0);

        lb = '0; add_run(100, 10); drive_line(50, lb);
        lb = '0; add_run(400, 10); drive_line(60, lb);
        frame_end("tie", 1'b0);

        lb = '0; add_run(630, 10); drive_line(1, lb);
        lb = '0; add_run(0, 5);    drive_line(2, lb);
        frame_end("edge_col", 1'b0);

        lb = '0; add_run(200, 20); drive_line(100, lb);
        frame_end("valid_again", 1'b0);
        lb = '0; add_run(400, 3);  drive_line(120, lb);
        frame_end("short_run", 1'b0);

        lb = '0; add_run(20, 5); drive_line(10, lb);
        frame_end("open_run", 1'b1);

        lb = '0; add_run(10, 200); drive_line(490, lb);
        lb = '0; add_run(50, 6);   drive_line(200, lb);
        frame_end("y_inactive", 1'b0);

        lb = '0; add_run(50, 100);
        for (int x = 0; x < 100; x++) cyc(lb[x], x, 5, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 100, 5, 1'b1, 1'b1);
        rst = 1'b0;
        exp_x = 0; exp_y = 0; exp_w = 0; exp_v = 1'b0;
        m_started = 1'b0; m_max = 0; m_end_x = 0; m_line = 0;
        check_outputs("midreset");
        check("midreset.frame_done", 32'(bus.frame_done), 32'd0);
        for (int x = 101; x < H_ACTIVE + 4; x++) cyc(x < 150, x, 5, 1'b1, 1'b1);
        frame_end("after_reset", 1'b0);
        lb = '0; add_run(77, 30); drive_line(40, lb);
        frame_end("recovered", 1'b0);

        for (int f = 0; f < 8; f++) begin
            int nl;
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                int y, nr;
                y  = ($urandom_range(0, 9) == 0) ? $urandom_range(V_ACTIVE, 511)
                                                 : $urandom_range(0, V_ACTIVE - 1);
                nr = $urandom_range(1, 4);
                lb = '0;
                for (int r = 0; r < nr; r++)
                    add_run($urandom_range(0, H_ACTIVE - 1), $urandom_range(1, 60));
                drive_line(y, lb);
            end
            frame_end("random", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
